// File: rtl/csr_counter_arbiter_if.sv
// Two-port CSR request/response bundle for the counter CSR arbiter.
// Port 0 is the execute stage, port 1 the debug/trace side.
interface csr_counter_arbiter_if;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0][11:0] req_addr;
    logic [1:0][1:0]  req_op;
    logic [1:0][31:0] req_wdata;
    logic [1:0]       resp_valid;
    logic [1:0]       resp_ready;
    logic [31:0]      resp_rdata;
    logic             resp_err;

    modport master (
        output req_valid, req_addr, req_op, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_addr, req_op, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/csr_counter_arbiter.sv
// mcycle/minstret/mcountinhibit owner shared by two round-robin ports,
// with per-port high-half snapshots for tear-free 64-bit reads.
module csr_counter_arbiter #(
    parameter bit HI_SNAPSHOT = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic instret_inc,
    csr_counter_arbiter_if.slave bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [1:0] OP_RD  = 2'b00;
    localparam logic [1:0] OP_WR  = 2'b01;
    localparam logic [1:0] OP_SET = 2'b10;
    localparam logic [1:0] OP_CLR = 2'b11;

    logic [1:0]       state;
    logic             gnt;
    logic             last_gnt;
    logic             pick;
    logic [11:0]      addr_q;
    logic [1:0]       op_q;
    logic [31:0]      wdata_q;
    logic [63:0]      mcycle;
    logic [63:0]      minstret;
    logic             inh_cy;
    logic             inh_ir;
    logic [1:0]       snap_cy_v;
    logic [1:0]       snap_ir_v;
    logic [1:0][31:0] snap_cy;
    logic [1:0][31:0] snap_ir;
    logic [31:0]      rdata_q;
    logic             err_q;

    logic        is_cl, is_ch, is_il, is_ih, is_inh;
    logic        shadow, mapped, eff_wr, err;
    logic        commit, rd_acc, snap_hit;
    logic [31:0] live, nval, rd_val;

    // Tie goes to the port not granted last; last_gnt resets to 1.
    assign pick = bus.req_valid[1] & (~bus.req_valid[0] | ~last_gnt);

    assign bus.req_ready = (state == IDLE && rst && |bus.req_valid)
                         ? (pick ? 2'b10 : 2'b01) : 2'b00;
    assign bus.resp_valid = (state == RESP)
                          ? (gnt ? 2'b10 : 2'b01) : 2'b00;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;

    always_comb begin
        is_cl  = (addr_q == 12'hB00) || (addr_q == 12'hC00);
        is_ch  = (addr_q == 12'hB80) || (addr_q == 12'hC80);
        is_il  = (addr_q == 12'hB02) || (addr_q == 12'hC02);
        is_ih  = (addr_q == 12'hB82) || (addr_q == 12'hC82);
        is_inh = (addr_q == 12'h320);
        shadow = (addr_q[11:8] == 4'hC);
        mapped = is_cl | is_ch | is_il | is_ih | is_inh;
        live   = 32'hFFFF_FFFF;
        unique case (1'b1)
            is_cl:   live = mcycle[31:0];
            is_ch:   live = mcycle[63:32];
            is_il:   live = minstret[31:0];
            is_ih:   live = minstret[63:32];
            is_inh:  live = {29'd0, inh_ir, 1'b0, inh_cy};
            default: live = 32'hFFFF_FFFF;
        endcase
        eff_wr = (op_q == OP_WR) ||
                 ((op_q != OP_RD) && (wdata_q != 32'd0));
        case (op_q)
            OP_WR:   nval = wdata_q;
            OP_SET:  nval = live | wdata_q;
            OP_CLR:  nval = live & ~wdata_q;
            default: nval = live;
        endcase
        err      = !mapped || (shadow && eff_wr);
        commit   = (state == EXEC) && !err && eff_wr;
        rd_acc   = (state == EXEC) && !err && !eff_wr;
        snap_hit = HI_SNAPSHOT && !eff_wr &&
                   ((is_ch && snap_cy_v[gnt]) ||
                    (is_ih && snap_ir_v[gnt]));
        rd_val = live;
        if (snap_hit)
            rd_val = is_ch ? snap_cy[gnt] : snap_ir[gnt];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            gnt      <= 1'b0;
            last_gnt <= 1'b1;
            addr_q   <= '0;
            op_q     <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (|bus.req_valid) begin
                    gnt      <= pick;
                    last_gnt <= pick;
                    addr_q   <= bus.req_addr[pick];
                    op_q     <= bus.req_op[pick];
                    wdata_q  <= bus.req_wdata[pick];
                    state    <= EXEC;
                end
                EXEC: begin
                    rdata_q <= rd_val;
                    err_q   <= err;
                    state   <= RESP;
                end
                RESP: if (bus.resp_ready[gnt])
                    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // A written counter skips its increment and never carries that cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcycle   <= '0;
            minstret <= '0;
            inh_cy   <= 1'b0;
            inh_ir   <= 1'b0;
        end else begin
            if (commit && is_cl)
                mcycle[31:0] <= nval;
            else if (commit && is_ch)
                mcycle[63:32] <= nval;
            else if (!inh_cy)
                mcycle <= mcycle + 64'd1;
            if (commit && is_il)
                minstret[31:0] <= nval;
            else if (commit && is_ih)
                minstret[63:32] <= nval;
            else if (instret_inc && !inh_ir)
                minstret <= minstret + 64'd1;
            if (commit && is_inh) begin
                inh_cy <= nval[0];
                inh_ir <= nval[2];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            snap_cy_v <= '0;
            snap_ir_v <= '0;
            snap_cy   <= '0;
            snap_ir   <= '0;
        end else begin
            if (commit && (is_cl || is_ch)) begin
                snap_cy_v <= '0;
            end else if (rd_acc && is_cl) begin
                snap_cy_v[gnt] <= HI_SNAPSHOT;
                snap_cy[gnt]   <= mcycle[63:32];
            end else if (rd_acc && is_ch) begin
                snap_cy_v[gnt] <= 1'b0;
            end
            if (commit && (is_il || is_ih)) begin
                snap_ir_v <= '0;
            end else if (rd_acc && is_il) begin
                snap_ir_v[gnt] <= HI_SNAPSHOT;
                snap_ir[gnt]   <= minstret[63:32];
            end else if (rd_acc && is_ih) begin
                snap_ir_v[gnt] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_csr_counter_arbiter.sv
// Directed bench for csr_counter_arbiter: counters, inhibit,
// snapshots, error responses and round-robin arbitration.
module tb_csr_counter_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic instret_inc = 1'b0;

    int edges  = 0;
    int checks = 0;
    int errors = 0;

    // mcycle model: value after edge e is cyc_base + (e - cyc_edge)
    logic [63:0] cyc_base = 64'd0;
    int          cyc_edge = 0;

    logic [31:0] rd;
    logic        er;
    int          acc;
    logic [63:0] frozen;
    int          gp[4];
    int          ge[4];
    int          ng;
    int          bad;

    csr_counter_arbiter_if bus ();

    csr_counter_arbiter #(.HI_SNAPSHOT(1'b1)) dut (
        .clk         (clk),
        .rst         (rst),
        .instret_inc (instret_inc),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (rst) edges <= edges + 1;

    function automatic logic [63:0] cyc_at(input int e);
        return cyc_base + 64'(e - cyc_edge);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input int n);
        repeat (n) begin
            @(negedge clk);
            instret_inc = 1'b1;
            @(negedge clk);
            instret_inc = 1'b0;
        end
    endtask

    task automatic access(input int p, input logic [11:0] a,
                          input logic [1:0] op, input logic [31:0] wd,
                          output logic [31:0] rdata, output logic err,
                          output int acc_e);
        bit got;
        rdata = 32'hDEAD_DEAD;
        err   = 1'bx;
        acc_e = -1;
        got   = 1'b0;
        @(negedge clk);
        bus.req_addr[p]  = a;
        bus.req_op[p]    = op;
        bus.req_wdata[p] = wd;
        bus.req_valid[p] = 1'b1;
        for (int i = 0; i < 20 && acc_e < 0; i++) begin
            #1;
            if (bus.req_ready[p]) acc_e = edges + 1;
            else @(negedge clk);
        end
        chk("accept_seen", 64'(acc_e >= 0), 64'd1);
        if (acc_e < 0) begin
            bus.req_valid[p] = 1'b0;
            return;
        end
        @(posedge clk);
        #1 bus.req_valid[p] = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (bus.resp_valid[p]) begin
                got   = 1'b1;
                rdata = bus.resp_rdata;
                err   = bus.resp_err;
                chk("resp_latency", 64'(edges), 64'(acc_e + 1));
            end
        end
        chk("resp_seen", 64'(got), 64'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        bus.req_valid  = 2'b00;
        bus.req_addr   = '0;
        bus.req_op     = '0;
        bus.req_wdata  = '0;
        bus.resp_ready = 2'b11;

        // reset state
        repeat (3) @(negedge clk);
        bus.req_valid = 2'b01;
        #1;
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("rst_resp_rdata", 64'(bus.resp_rdata), 64'd0);
        chk("rst_resp_err", 64'(bus.resp_err), 64'd0);
        bus.req_valid = 2'b00;
        @(negedge clk);
        rst = 1'b1;

        // free running mcycle through the shadow
        access(0, 12'hC00, 2'b00, 32'd0, rd, er, acc);
        chk("c00_rdata", 64'(rd), 64'(acc));
        chk("c00_err", 64'(er), 64'd0);

        // write low half, no carry that cycle, then wrap into high
        access(0, 12'hB00, 2'b01, 32'hFFFF_FFFF, rd, er, acc);
        chk("wr_b00_old", 64'(rd), cyc_at(acc) & 64'hFFFF_FFFF);
        cyc_base = 64'h0000_0000_FFFF_FFFF;
        cyc_edge = acc + 1;
        access(0, 12'hB80, 2'b00, 32'd0, rd, er, acc);
        chk("b80_after_wrap", 64'(rd), 64'h1);
        chk("b80_model", 64'(rd), cyc_at(acc) >> 32);
        access(0, 12'hB00, 2'b00, 32'd0, rd, er, acc);
        chk("b00_after_wrap", 64'(rd), cyc_at(acc) & 64'hFFFF_FFFF);

        // minstret counts pulses
        pulse(2);
        access(0, 12'hC02, 2'b00, 32'd0, rd, er, acc);
        chk("c02_two", 64'(rd), 64'd2);

        // inhibit both counters
        access(0, 12'h320, 2'b10, 32'h5, rd, er, acc);
        chk("inh_set_old", 64'(rd), 64'd0);
        chk("inh_set_err", 64'(er), 64'd0);
        frozen = cyc_at(acc + 1);
        pulse(3);
        access(0, 12'hB00, 2'b00, 32'd0, rd, er, acc);
        chk("cy_frozen_a", 64'(rd), frozen & 64'hFFFF_FFFF);
        access(0, 12'hB02, 2'b00, 32'd0, rd, er, acc);
        chk("ir_frozen", 64'(rd), 64'd2);
        access(0, 12'hB00, 2'b00, 32'd0, rd, er, acc);
        chk("cy_frozen_b", 64'(rd), frozen & 64'hFFFF_FFFF);
        access(0, 12'h320, 2'b11, 32'h1, rd, er, acc);
        chk("inh_clr_old", 64'(rd), 64'h5);
        cyc_base = frozen;
        cyc_edge = acc + 1;
        access(0, 12'hB00, 2'b00, 32'd0, rd, er, acc);
        chk("cy_resumed", 64'(rd), cyc_at(acc) & 64'hFFFF_FFFF);
        pulse(1);
        access(0, 12'hB02, 2'b00, 32'd0, rd, er, acc);
        chk("ir_still_frozen", 64'(rd), 64'd2);

        // snapshot keeps the high half consistent with the low read
        access(0, 12'hB80, 2'b01, 32'h1, rd, er, acc);
        chk("wr_b80_old", 64'(rd), cyc_at(acc) >> 32);
        access(0, 12'hB00, 2'b01, 32'hFFFF_FFF0, rd, er, acc);
        cyc_base = 64'h0000_0001_FFFF_FFF0;
        cyc_edge = acc + 1;
        access(0, 12'hB00, 2'b00, 32'd0, rd, er, acc);
        chk("snap_lo", 64'(rd), cyc_at(acc) & 64'hFFFF_FFFF);
        repeat (20) @(negedge clk);
        access(0, 12'hB80, 2'b00, 32'd0, rd, er, acc);
        chk("snap_hi", 64'(rd), 64'h1);
        access(0, 12'hB80, 2'b00, 32'd0, rd, er, acc);
        chk("live_hi", 64'(rd), 64'h2);
        chk("live_hi_model", 64'(rd), cyc_at(acc) >> 32);

        // error responses from port 1
        access(1, 12'hC02, 2'b01, 32'h1234, rd, er, acc);
        chk("ro_wr_err", 64'(er), 64'd1);
        chk("ro_wr_rdata", 64'(rd), 64'd2);
        access(1, 12'hB02, 2'b00, 32'd0, rd, er, acc);
        chk("ro_wr_nochg", 64'(rd), 64'd2);
        chk("ro_rd_err", 64'(er), 64'd0);
        access(1, 12'h7FF, 2'b00, 32'd0, rd, er, acc);
        chk("unmapped_err", 64'(er), 64'd1);
        chk("unmapped_rdata", 64'(rd), 64'hFFFF_FFFF);
        access(1, 12'hC00, 2'b10, 32'd0, rd, er, acc);
        chk("set0_err", 64'(er), 64'd0);
        chk("set0_rdata", 64'(rd), cyc_at(acc) & 64'hFFFF_FFFF);

        // both ports requesting: alternate grants, 3 cycles apart
        @(negedge clk);
        bus.req_addr  = {12'hB02, 12'hB02};
        bus.req_op    = '0;
        bus.req_wdata = '0;
        bus.req_valid = 2'b11;
        ng = 0;
        for (int i = 0; i < 30 && ng < 4; i++) begin
            #1;
            if (bus.req_ready != 2'b00) begin
                gp[ng] = bus.req_ready[1] ? 1 : 0;
                ge[ng] = edges;
                chk("rr_onehot", 64'($countones(bus.req_ready)), 64'd1);
                ng++;
            end
            @(negedge clk);
        end
        bus.req_valid = 2'b00;
        chk("rr_grants", 64'(ng), 64'd4);
        chk("rr_g0", 64'(gp[0]), 64'd0);
        chk("rr_g1", 64'(gp[1]), 64'd1);
        chk("rr_g2", 64'(gp[2]), 64'd0);
        chk("rr_g3", 64'(gp[3]), 64'd1);
        chk("rr_gap1", 64'(ge[1] - ge[0]), 64'd3);
        chk("rr_gap3", 64'(ge[3] - ge[2]), 64'd3);
        repeat (4) @(negedge clk);

        // port 0 response stalled: port 1 must wait
        bus.resp_ready = 2'b10;
        bus.req_valid  = 2'b11;
        #1;
        chk("stall_grant0", 64'(bus.req_ready), 64'h1);
        @(posedge clk);
        #1 bus.req_valid[0] = 1'b0;
        bad = 0;
        @(negedge clk);
        repeat (5) begin
            @(negedge clk);
            if (bus.req_ready != 2'b00) bad++;
            if (bus.resp_valid != 2'b01) bad++;
        end
        chk("stall_hold", 64'(bad), 64'd0);
        bus.resp_ready[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("stall_then_g1", 64'(bus.req_ready), 64'h2);
        @(posedge clk);
        #1 bus.req_valid = 2'b00;
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
